inst_b_enc: RTL and testbench

- Encodes RISC-V B-type conditional branches (BEQ/BNE/BLT/BGE/BLTU/BGEU) from fields into 32-bit instruction words. This is the inverse of the B-type field decoder.
- Used by the self-test program generator and the instruction-memory loader to build branch words on the fly.
- Two-stage elastic pipeline with valid/ready on both sides.
- Validates its inputs and flags illegal requests. Keeps running counts of good and bad encodes.

---
 rtl/inst_b_enc_pkg.sv | 24 ++
 rtl/b_imm_pack.sv | 18 +
 rtl/inst_b_enc.sv | 104 ++++++++++
 tb/tb_inst_b_enc.sv | 241 ++++++++++++++++++++++++
 4 files changed

// File: rtl/inst_b_enc_pkg.sv
// Shared constants for the RISC-V B-type branch encoder.
package inst_b_enc_pkg;

    localparam logic [6:0]  OPC_BRANCH = 7'b1100011;
    localparam logic [31:0] NOP_WORD   = 32'h0000_0013;

    localparam logic [2:0] F3_BEQ  = 3'b000;
    localparam logic [2:0] F3_BNE  = 3'b001;
    localparam logic [2:0] F3_BLT  = 3'b100;
    localparam logic [2:0] F3_BGE  = 3'b101;
    localparam logic [2:0] F3_BLTU = 3'b110;
    localparam logic [2:0] F3_BGEU = 3'b111;

    localparam logic [1:0] ERR_OK    = 2'b00;
    localparam logic [1:0] ERR_F3    = 2'b01;
    localparam logic [1:0] ERR_RANGE = 2'b10;
    localparam logic [1:0] ERR_ALIGN = 2'b11;

    function automatic logic f3_legal(input logic [2:0] f3);
        return (f3 == F3_BEQ) || (f3 == F3_BNE) || (f3 == F3_BLT) ||
               (f3 == F3_BGE) || (f3 == F3_BLTU) || (f3 == F3_BGEU);
    endfunction

endpackage

// File: rtl/b_imm_pack.sv
// Combinational B-type word packer: scatters the 13-bit branch immediate
// around the register and funct3 fields.
module b_imm_pack
    import inst_b_enc_pkg::*;
(
    input  logic [2:0]  funct3,
    input  logic [4:0]  rs1,
    input  logic [4:0]  rs2,
    input  logic [12:0] imm,
    output logic [31:0] word
);
    // Bit 0 of a branch offset is implied zero and never encoded.
    logic unused_imm0;
    assign unused_imm0 = imm[0];

    assign word = {imm[12], imm[10:5], rs2, rs1, funct3, imm[4:1], imm[11], OPC_BRANCH};

endmodule

// File: rtl/inst_b_enc.sv
// Two-stage elastic encoder for RISC-V B-type branch words with input checking
// and running counts of good and errored words delivered.
module inst_b_enc
    import inst_b_enc_pkg::*;
#(
    parameter int unsigned CNT_W   = 16,
    parameter bit          ERR_NOP = 1'b1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [2:0]       funct3_in,
    input  logic [4:0]       rs1_in,
    input  logic [4:0]       rs2_in,
    input  logic [31:0]      offset_in,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [31:0]      instr_out,
    output logic [1:0]       err_out,
    output logic [CNT_W-1:0] enc_count,
    output logic [CNT_W-1:0] err_count
);
    localparam logic [CNT_W-1:0] CNT_ONE = {{(CNT_W-1){1'b0}}, 1'b1};

    logic        run;
    logic        s1_valid;
    logic [2:0]  s1_funct3;
    logic [4:0]  s1_rs1;
    logic [4:0]  s1_rs2;
    logic [12:0] s1_imm;
    logic [1:0]  s1_err;
    logic [1:0]  chk_err;
    logic [31:0] packed_word;
    logic [31:0] s2_word;
    logic        s2_adv;

    // run holds in_ready low while reset is applied and releases it one edge later.
    assign s2_adv   = !out_valid || out_ready;
    assign in_ready = run && (!s1_valid || s2_adv);

    always_comb begin
        chk_err = ERR_OK;
        if (!f3_legal(funct3_in))
            chk_err = ERR_F3;
        else if (offset_in[31:12] != {20{offset_in[12]}})
            chk_err = ERR_RANGE;
        else if (offset_in[0])
            chk_err = ERR_ALIGN;
    end

    b_imm_pack u_pack (
        .funct3 (s1_funct3),
        .rs1    (s1_rs1),
        .rs2    (s1_rs2),
        .imm    (s1_imm),
        .word   (packed_word)
    );

    assign s2_word = (ERR_NOP && (s1_err != ERR_OK)) ? NOP_WORD : packed_word;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            run       <= 1'b0;
            s1_valid  <= 1'b0;
            s1_funct3 <= '0;
            s1_rs1    <= '0;
            s1_rs2    <= '0;
            s1_imm    <= '0;
            s1_err    <= ERR_OK;
            out_valid <= 1'b0;
            instr_out <= '0;
            err_out   <= ERR_OK;
            enc_count <= '0;
            err_count <= '0;
        end else begin
            run <= 1'b1;
            if (in_ready) begin
                s1_valid <= in_valid;
                if (in_valid) begin
                    s1_funct3 <= funct3_in;
                    s1_rs1    <= rs1_in;
                    s1_rs2    <= rs2_in;
                    s1_imm    <= offset_in[12:0];
                    s1_err    <= chk_err;
                end
            end
            if (s2_adv) begin
                out_valid <= s1_valid;
                if (s1_valid) begin
                    instr_out <= s2_word;
                    err_out   <= s1_err;
                end
            end
            if (out_valid && out_ready) begin
                if (err_out == ERR_OK)
                    enc_count <= enc_count + CNT_ONE;
                else
                    err_count <= err_count + CNT_ONE;
            end
        end
    end

endmodule

// File: tb/tb_inst_b_enc.sv
// Directed and scoreboarded bench for the B-type branch encoder.
module tb_inst_b_enc;
    import inst_b_enc_pkg::*;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  funct3_in;
    logic [4:0]  rs1_in;
    logic [4:0]  rs2_in;
    logic [31:0] offset_in;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] instr_out;
    logic [1:0]  err_out;
    logic [15:0] enc_count;
    logic [15:0] err_count;

    inst_b_enc #(.CNT_W(16), .ERR_NOP(1'b1)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .funct3_in (funct3_in),
        .rs1_in    (rs1_in),
        .rs2_in    (rs2_in),
        .offset_in (offset_in),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .instr_out (instr_out),
        .err_out   (err_out),
        .enc_count (enc_count),
        .err_count (err_count)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [2:0]  f3;
        logic [4:0]  rs1;
        logic [4:0]  rs2;
        logic [31:0] off;
        logic [31:0] ex_word;
        logic [1:0]  ex_err;
    } vec_t;

    vec_t        vecs [10];
    logic [33:0] exp_q [$];
    logic [33:0] mon_e;
    int          total = 0;
    int          bad = 0;
    int          exp_enc = 0;
    int          exp_errn = 0;
    bit          rand_rdy = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: got %0h, required %0h", name, act, req);
        end
    endtask

    // Reference encoder written straight from the field layout.
    function automatic logic [33:0] model(input logic [2:0] f3, input logic [4:0] a,
                                          input logic [4:0] b, input logic [31:0] off);
        logic [1:0]  e;
        logic [31:0] w;
        logic [12:0] imm;
        imm = off[12:0];
        if (f3 == 3'd2 || f3 == 3'd3)                   e = 2'd1;
        else if ($signed(off) < -4096 || $signed(off) > 4095) e = 2'd2;
        else if (off[0])                                e = 2'd3;
        else                                            e = 2'd0;
        w = {imm[12], imm[10:5], b, a, f3, imm[4:1], imm[11], 7'b1100011};
        if (e != 2'd0) w = 32'h0000_0013;
        return {e, w};
    endfunction

    // Called just after a rising edge; returns just after the accepting edge.
    task automatic send(input logic [2:0] f3, input logic [4:0] a, input logic [4:0] b,
                        input logic [31:0] off, input logic [33:0] ex);
        int n = 0;
        in_valid = 1'b1; funct3_in = f3; rs1_in = a; rs2_in = b; offset_in = off;
        @(negedge clk);
        while (!in_ready && n < 200) begin n++; @(negedge clk); end
        if (!in_ready) begin
            total++; bad++;
            $display("FAIL accept_timeout: in_ready=0, required 1");
        end else begin
            exp_q.push_back(ex);
            if (ex[33:32] == 2'd0) exp_enc++; else exp_errn++;
        end
        @(posedge clk); #1;
    endtask

    always @(negedge clk) begin
        if (!rst && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                total++; bad++;
                $display("FAIL extra_word: got %0h, required no word", instr_out);
            end else begin
                mon_e = exp_q.pop_front();
                check("word", 64'(instr_out), 64'(mon_e[31:0]));
                check("err_code", 64'(err_out), 64'(mon_e[33:32]));
            end
        end
    end

    always @(posedge clk) begin
        if (rand_rdy) begin
            #1 out_ready = 1'($urandom_range(0, 1));
        end
    end

    initial begin
        logic [33:0] ea, eb, ec;
        logic [2:0]  rf3;
        logic [31:0] roff;
        int          n;

        in_valid = 1'b0; funct3_in = '0; rs1_in = '0; rs2_in = '0; offset_in = '0; out_ready = 1'b1;

        vecs[0] = '{3'd0, 5'd1,  5'd2,  32'd8,           32'h0020_8463, 2'd0};
        vecs[1] = '{3'd1, 5'd5,  5'd0,  -32'sd4,         32'hFE02_9EE3, 2'd0};
        vecs[2] = '{3'd4, 5'd3,  5'd4,  -32'sd4096,      32'h8041_C063, 2'd0};
        vecs[3] = '{3'd5, 5'd31, 5'd31, 32'd4094,        32'h7FFF_DFE3, 2'd0};
        vecs[4] = '{3'd6, 5'd0,  5'd7,  32'd256,         32'h1070_6063, 2'd0};
        vecs[5] = '{3'd7, 5'd10, 5'd11, 32'd2048,        32'h00B5_70E3, 2'd0};
        vecs[6] = '{3'd2, 5'd1,  5'd2,  32'd8,           32'h0000_0013, 2'd1};
        vecs[7] = '{3'd0, 5'd1,  5'd2,  32'd4096,        32'h0000_0013, 2'd2};
        vecs[8] = '{3'd0, 5'd1,  5'd2,  32'd7,           32'h0000_0013, 2'd3};
        vecs[9] = '{3'd3, 5'd1,  5'd2,  32'd5000,        32'h0000_0013, 2'd1};

        #3;
        check("rst_in_ready",  64'(in_ready),  64'd0);
        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_instr",     64'(instr_out), 64'd0);
        check("rst_err",       64'(err_out),   64'd0);
        check("rst_enc_count", 64'(enc_count), 64'd0);
        check("rst_err_count", 64'(err_count), 64'd0);
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        #1 check("in_ready_before_edge", 64'(in_ready), 64'd0);
        @(negedge clk) check("in_ready_after_edge", 64'(in_ready), 64'd1);
        @(posedge clk); #1;

        for (int i = 0; i < 10; i++) begin
            send(vecs[i].f3, vecs[i].rs1, vecs[i].rs2, vecs[i].off, {vecs[i].ex_err, vecs[i].ex_word});
            in_valid = 1'b0;
            @(negedge clk) check("latency_early", 64'(out_valid), 64'd0);
            @(negedge clk) check("latency_due",   64'(out_valid), 64'd1);
            @(negedge clk);
            if (i == 0) check("enc_count_first", 64'(enc_count), 64'd1);
            @(posedge clk); #1;
        end
        check("table_enc_count", 64'(enc_count), 64'd6);
        check("table_err_count", 64'(err_count), 64'd4);

        // Stall: two requests fill the pipe, third must wait.
        out_ready = 1'b0;
        ea = model(3'd0, 5'd3, 5'd4, 32'd16);
        eb = model(3'd1, 5'd6, 5'd7, -32'sd32);
        ec = model(3'd2, 5'd1, 5'd1, 32'd0);
        send(3'd0, 5'd3, 5'd4, 32'd16, ea);
        send(3'd1, 5'd6, 5'd7, -32'sd32, eb);
        in_valid = 1'b1; funct3_in = 3'd2; rs1_in = 5'd1; rs2_in = 5'd1; offset_in = 32'd0;
        repeat (3) begin
            @(negedge clk);
            check("stall_in_ready", 64'(in_ready),  64'd0);
            check("stall_valid",    64'(out_valid), 64'd1);
            check("stall_word",     64'(instr_out), 64'(ea[31:0]));
        end
        @(posedge clk); #1;
        out_ready = 1'b1;
        send(3'd2, 5'd1, 5'd1, 32'd0, ec);
        in_valid = 1'b0;
        @(negedge clk) check("burst_second", 64'(out_valid), 64'd1);
        @(negedge clk) check("burst_third",  64'(out_valid), 64'd1);
        @(posedge clk); #1;

        // Random stream with toggling back-pressure.
        rand_rdy = 1'b1;
        for (int i = 0; i < 20; i++) begin
            rf3 = 3'($urandom_range(0, 7));
            case ($urandom_range(0, 4))
                0:       roff = 32'($urandom_range(0, 2047)) << 1;
                1:       roff = -(32'($urandom_range(1, 2048)) << 1);
                2:       roff = (32'($urandom_range(0, 1000)) << 1) + 32'd1;
                3:       roff = 32'd8192;
                default: roff = -32'sd5000;
            endcase
            rs1_in = 5'($urandom_range(0, 31));
            rs2_in = 5'($urandom_range(0, 31));
            send(rf3, rs1_in, rs2_in, roff, model(rf3, rs1_in, rs2_in, roff));
            if ($urandom_range(0, 3) == 0) begin
                in_valid = 1'b0;
                @(posedge clk); #1;
            end
        end
        in_valid = 1'b0;
        rand_rdy = 1'b0;
        @(posedge clk); #2;
        out_ready = 1'b1;
        n = 0;
        while (exp_q.size() != 0 && n < 100) begin n++; @(negedge clk); end
        if (exp_q.size() != 0) begin
            total++; bad++;
            $display("FAIL drain_timeout: %0d words pending, required 0", exp_q.size());
        end
        @(negedge clk);
        check("stream_enc_count", 64'(enc_count), 64'(16'(exp_enc)));
        check("stream_err_count", 64'(err_count), 64'(16'(exp_errn)));

        // Asynchronous reset with two requests in flight.
        @(posedge clk); #1;
        out_ready = 1'b0;
        send(3'd0, 5'd1, 5'd1, 32'd4, model(3'd0, 5'd1, 5'd1, 32'd4));
        send(3'd1, 5'd2, 5'd2, 32'd6, model(3'd1, 5'd2, 5'd2, 32'd6));
        in_valid = 1'b0;
        @(negedge clk); #2;
        rst = 1'b1;
        #1;
        check("async_out_valid", 64'(out_valid), 64'd0);
        check("async_enc_count", 64'(enc_count), 64'd0);
        check("async_err_count", 64'(err_count), 64'd0);
        check("async_in_ready",  64'(in_ready),  64'd0);
        check("async_instr",     64'(instr_out), 64'd0);
        exp_q.delete();
        @(negedge clk); @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        repeat (5) @(negedge clk) check("no_stale_word", 64'(out_valid), 64'd0);
        check("post_rst_in_ready", 64'(in_ready), 64'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
